// File: rtl/ext_mem_fwd_pkg.sv
// Shared types and constants for the external-memory request forwarder.
package ext_mem_fwd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fwd_state_t;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_ILLEGAL = 2'd1;
    localparam logic [1:0] RSP_TIMEOUT = 2'd2;

    function automatic logic rsp_is_err(input logic [1:0] rsp);
        return (rsp != RSP_OK);
    endfunction

endpackage

// File: rtl/ext_mem_fwd_timer.sv
// Wait-state timeout counter and saturating count of timeouts seen since reset.
module ext_mem_fwd_timer #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 tmo_inc,
    output logic                 expire,
    output logic [CNT_WIDTH-1:0] tmo_cnt
);

    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0]    LAST_CNT = WAIT_W'(TIMEOUT_CYC - 1);
    localparam logic [WAIT_W-1:0]    WAIT_ONE = WAIT_W'(1);
    localparam logic [CNT_WIDTH-1:0] TMO_ONE  = CNT_WIDTH'(1);

    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [CNT_WIDTH-1:0] tmo_cnt_r;

    assign expire  = (wait_cnt_r == LAST_CNT);
    assign tmo_cnt = tmo_cnt_r;

    // Wait counter: cleared on entry to WAIT, stops at the expiry value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (clr) begin
            wait_cnt_r <= '0;
        end else if (en && !expire) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Timeout event counter, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= '0;
        end else if (tmo_inc && (tmo_cnt_r != {CNT_WIDTH{1'b1}})) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

endmodule

// File: rtl/ext_mem_fwd.sv
// Upstream request stage: replays one request to the memory, waits for ack and
// turns a missing ack into a timeout error response.
module ext_mem_fwd
    import ext_mem_fwd_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 6,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_req_vld,
    input  logic                  s_wr_en,
    input  logic                  s_rd_en,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_wr_data,
    output logic                  s_ack_vld,
    output logic [DATA_WIDTH-1:0] s_rd_data,
    output logic                  s_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  tmo_cnt,
    output logic                  m_req_vld,
    output logic                  m_wr_en,
    output logic                  m_rd_en,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wr_data,
    input  logic                  m_ack_vld,
    input  logic [DATA_WIDTH-1:0] m_rd_data
);

    fwd_state_t            state_r, state_s;
    logic                  m_req_vld_r, m_req_vld_s;
    logic                  m_wr_en_r, m_wr_en_s;
    logic                  m_rd_en_r, m_rd_en_s;
    logic [ADDR_WIDTH-1:0] m_addr_r, m_addr_s;
    logic [DATA_WIDTH-1:0] m_wr_data_r, m_wr_data_s;
    logic                  s_ack_vld_r, s_ack_vld_s;
    logic [DATA_WIDTH-1:0] s_rd_data_r, s_rd_data_s;
    logic                  s_err_r;
    logic                  busy_r;
    logic [1:0]            rsp_s;
    logic                  clr_s, en_s, tmo_inc_s, expire_s;
    logic                  done_s;

    ext_mem_fwd_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_s),
        .en      (en_s),
        .tmo_inc (tmo_inc_s),
        .expire  (expire_s),
        .tmo_cnt (tmo_cnt)
    );

    // Next-state, capture and response decode.
    always_comb begin
        state_s     = state_r;
        m_req_vld_s = 1'b0;
        m_wr_en_s   = m_wr_en_r;
        m_rd_en_s   = m_rd_en_r;
        m_addr_s    = m_addr_r;
        m_wr_data_s = m_wr_data_r;
        s_ack_vld_s = 1'b0;
        s_rd_data_s = '0;
        rsp_s       = RSP_OK;
        clr_s       = 1'b0;
        en_s        = 1'b0;
        tmo_inc_s   = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (s_req_vld && (s_wr_en ^ s_rd_en)) begin
                    m_req_vld_s = 1'b1;
                    m_wr_en_s   = s_wr_en;
                    m_rd_en_s   = s_rd_en;
                    m_addr_s    = s_addr;
                    m_wr_data_s = s_wr_data;
                    state_s     = ST_ISSUE;
                end else if (s_req_vld && s_wr_en && s_rd_en) begin
                    s_ack_vld_s = 1'b1;
                    rsp_s       = RSP_ILLEGAL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                clr_s = 1'b1;
                if (m_ack_vld) begin
                    done_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                en_s = 1'b1;
                if (m_ack_vld) begin
                    done_s = 1'b1;
                end else if (expire_s) begin
                    done_s    = 1'b1;
                    rsp_s     = RSP_TIMEOUT;
                    tmo_inc_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                done_s = 1'b1;
                rsp_s  = RSP_ILLEGAL;
            end
        endcase
        // Completion: respond upstream and drop the memory-side command.
        if (done_s) begin
            state_s     = ST_IDLE;
            s_ack_vld_s = 1'b1;
            s_rd_data_s = (m_rd_en_r && (rsp_s == RSP_OK)) ? m_rd_data : '0;
            m_wr_en_s   = 1'b0;
            m_rd_en_s   = 1'b0;
            m_addr_s    = '0;
            m_wr_data_s = '0;
        end else begin
            s_rd_data_s = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            m_req_vld_r <= 1'b0;
            m_wr_en_r   <= 1'b0;
            m_rd_en_r   <= 1'b0;
            m_addr_r    <= '0;
            m_wr_data_r <= '0;
            s_ack_vld_r <= 1'b0;
            s_rd_data_r <= '0;
            s_err_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            m_req_vld_r <= m_req_vld_s;
            m_wr_en_r   <= m_wr_en_s;
            m_rd_en_r   <= m_rd_en_s;
            m_addr_r    <= m_addr_s;
            m_wr_data_r <= m_wr_data_s;
            s_ack_vld_r <= s_ack_vld_s;
            s_rd_data_r <= s_rd_data_s;
            s_err_r     <= s_ack_vld_s && rsp_is_err(rsp_s);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign m_req_vld = m_req_vld_r;
    assign m_wr_en   = m_wr_en_r;
    assign m_rd_en   = m_rd_en_r;
    assign m_addr    = m_addr_r;
    assign m_wr_data = m_wr_data_r;
    assign s_ack_vld = s_ack_vld_r;
    assign s_rd_data = s_rd_data_r;
    assign s_err     = s_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ext_mem_fwd.sv
// Directed bench for ext_mem_fwd paired with a small behavioural memory model.
module tb_ext_mem_fwd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_req_vld = 1'b0;
    logic        s_wr_en = 1'b0;
    logic        s_rd_en = 1'b0;
    logic [5:0]  s_addr = 6'd0;
    logic [31:0] s_wr_data = 32'd0;
    logic        s_ack_vld;
    logic [31:0] s_rd_data;
    logic        s_err;
    logic        busy;
    logic [7:0]  tmo_cnt;
    logic        m_req_vld;
    logic        m_wr_en;
    logic        m_rd_en;
    logic [5:0]  m_addr;
    logic [31:0] m_wr_data;

    // memory model
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rd = 32'd0;
    logic [31:0] mem [64];
    int          mem_cnt = 0;
    logic        mw = 1'b0;
    logic [5:0]  ma = 6'd0;
    logic [31:0] md = 32'd0;
    logic        dbg_err = 1'b0;
    int          mem_lat = 2;

    int req_cnt = 0;
    int ack_cnt = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ext_mem_fwd #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (6),
        .TIMEOUT_CYC (16),
        .CNT_WIDTH   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_req_vld (s_req_vld),
        .s_wr_en   (s_wr_en),
        .s_rd_en   (s_rd_en),
        .s_addr    (s_addr),
        .s_wr_data (s_wr_data),
        .s_ack_vld (s_ack_vld),
        .s_rd_data (s_rd_data),
        .s_err     (s_err),
        .busy      (busy),
        .tmo_cnt   (tmo_cnt),
        .m_req_vld (m_req_vld),
        .m_wr_en   (m_wr_en),
        .m_rd_en   (m_rd_en),
        .m_addr    (m_addr),
        .m_wr_data (m_wr_data),
        .m_ack_vld (mem_ack),
        .m_rd_data (mem_rd)
    );

    // Memory acks mem_lat cycles after the request pulse; no ack while dbg_err is set.
    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (m_req_vld && !dbg_err) begin
            mem_cnt <= mem_lat - 1;
            mw      <= m_wr_en;
            ma      <= m_addr;
            md      <= m_wr_data;
        end else if (mem_cnt > 0) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) begin
                mem_ack <= 1'b1;
                if (mw) mem[ma] <= md;
                else    mem_rd  <= mem[ma];
            end
        end
    end

    // Pulse counters for request and completion strobes.
    always @(posedge clk) begin
        if (m_req_vld) req_cnt <= req_cnt + 1;
        if (s_ack_vld) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic re, input logic [5:0] a, input logic [31:0] d);
        s_req_vld = 1'b1;
        s_wr_en   = we;
        s_rd_en   = re;
        s_addr    = a;
        s_wr_data = d;
        tick();
        s_req_vld = 1'b0;
        s_wr_en   = 1'b0;
        s_rd_en   = 1'b0;
        s_addr    = 6'd0;
        s_wr_data = 32'd0;
    endtask

    task automatic wait_ack(input int start, output int cyc);
        cyc = start;
        while (!s_ack_vld && cyc < start + 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int c;
        int r0;
        int a0;

        // reset
        tick();
        tick();
        chk("rst_ack", 64'(s_ack_vld), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tmo", 64'(tmo_cnt), 64'd0);
        chk("rst_mreq", 64'(m_req_vld), 64'd0);
        chk("rst_maddr", 64'(m_addr), 64'd0);
        #4 rst_n = 1'b1;
        tick();

        // 1: write
        issue(1'b1, 1'b0, 6'h05, 32'hDEADBEEF);
        chk("t1_mreq_c1", 64'(m_req_vld), 64'd1);
        chk("t1_mwr", 64'(m_wr_en), 64'd1);
        chk("t1_maddr", 64'(m_addr), 64'h05);
        chk("t1_mdata", 64'(m_wr_data), 64'hDEADBEEF);
        chk("t1_busy_c1", 64'(busy), 64'd1);
        tick();
        chk("t1_mreq_c2", 64'(m_req_vld), 64'd0);
        chk("t1_maddr_c2", 64'(m_addr), 64'h05);
        wait_ack(2, c);
        chk("t1_ack_cyc", 64'(c), 64'd4);
        chk("t1_err", 64'(s_err), 64'd0);
        chk("t1_rdata", 64'(s_rd_data), 64'd0);
        chk("t1_busy_c4", 64'(busy), 64'd0);
        chk("t1_mwr_c4", 64'(m_wr_en), 64'd0);
        tick();
        chk("t1_ack_c5", 64'(s_ack_vld), 64'd0);

        // 2: read back
        issue(1'b0, 1'b1, 6'h05, 32'd0);
        chk("t2_mrd", 64'(m_rd_en), 64'd1);
        wait_ack(1, c);
        chk("t2_ack_cyc", 64'(c), 64'd4);
        chk("t2_rdata", 64'(s_rd_data), 64'hDEADBEEF);
        chk("t2_err", 64'(s_err), 64'd0);
        tick();

        // 3: timeout
        dbg_err = 1'b1;
        issue(1'b0, 1'b1, 6'h01, 32'd0);
        wait_ack(1, c);
        chk("t3_ack_cyc", 64'(c), 64'd18);
        chk("t3_err", 64'(s_err), 64'd1);
        chk("t3_rdata", 64'(s_rd_data), 64'd0);
        chk("t3_tmo", 64'(tmo_cnt), 64'd1);
        chk("t3_busy", 64'(busy), 64'd0);
        dbg_err = 1'b0;
        tick();

        // 4: both enables
        r0 = req_cnt;
        issue(1'b1, 1'b1, 6'h02, 32'h11);
        chk("t4_ack", 64'(s_ack_vld), 64'd1);
        chk("t4_err", 64'(s_err), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        tick();
        tick();
        chk("t4_no_mreq", 64'(req_cnt - r0), 64'd0);
        chk("t4_tmo", 64'(tmo_cnt), 64'd1);

        // 5: request while busy is dropped, request in cycle 4 served
        r0 = req_cnt;
        a0 = ack_cnt;
        issue(1'b0, 1'b1, 6'h05, 32'd0);
        tick();
        issue(1'b1, 1'b0, 6'h09, 32'h1234);
        wait_ack(3, c);
        chk("t5_ack_cyc", 64'(c), 64'd4);
        chk("t5_rdata", 64'(s_rd_data), 64'hDEADBEEF);
        issue(1'b1, 1'b0, 6'h05, 32'h0BADF00D);
        chk("t5_mreq2", 64'(m_req_vld), 64'd1);
        chk("t5_maddr2", 64'(m_addr), 64'h05);
        wait_ack(1, c);
        chk("t5_ack2_cyc", 64'(c), 64'd4);
        tick();
        chk("t5_req_cnt", 64'(req_cnt - r0), 64'd2);
        chk("t5_ack_cnt", 64'(ack_cnt - a0), 64'd2);

        // 6: reset in WAIT, late ack ignored, then normal write/read
        mem_lat = 6;
        issue(1'b1, 1'b0, 6'h0A, 32'h55AA);
        tick();
        tick();
        chk("t6_busy_wait", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_mwr", 64'(m_wr_en), 64'd0);
        chk("t6_rst_maddr", 64'(m_addr), 64'd0);
        chk("t6_rst_tmo", 64'(tmo_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        a0 = ack_cnt;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_late_ack", 64'(ack_cnt - a0), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);
        mem_lat = 2;
        issue(1'b1, 1'b0, 6'h0B, 32'hCAFE);
        wait_ack(1, c);
        chk("t6_wr_cyc", 64'(c), 64'd4);
        chk("t6_wr_err", 64'(s_err), 64'd0);
        tick();
        issue(1'b0, 1'b1, 6'h0B, 32'd0);
        wait_ack(1, c);
        chk("t6_rd_cyc", 64'(c), 64'd4);
        chk("t6_rdata", 64'(s_rd_data), 64'hCAFE);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
